sram_cmd_sched: RTL and testbench
=================================

// Module: sram_cmd_sched
// PURPOSE
//  Sequences 32-bit read/write commands into one single-port toy SRAM macro.
//  Shares the SRAM between two requesters:
//    - the Wishbone-slave command interface (cmd_*): one-cycle pulses, no backpressure;
//    - an internal test-engine port (tst_*): valid/ready handshake.
//  Buffers Wishbone commands, round-robin arbitrates, waits out SRAM read latency, returns read data.
// PARAMETERS
//  ADDR_W    8  SRAM word-address width; sram_adr = cmd_adr[ADDR_W+1:2] / tst_adr[ADDR_W-1:0]
//  RD_LAT    1  cycles from sram_en (read) to sram_rdat valid; legal range 1..15
//  WB_DEPTH  2  Wishbone command FIFO depth; power of 2, >=2
// PORTS
//  clk         in   1       clock
//  rst         in   1       synchronous, active-high reset
//  cmd_val     in   1       Wishbone command pulse (one cycle per command)
//  cmd_adr     in   32      Wishbone byte address
//  cmd_we      in   1       1=write, 0=read
//  cmd_sel     in   4       byte enables
//  cmd_dat     in   32      write data
//  rd_ack      out  1       one-cycle pulse, Wishbone read data valid
//  rd_dat      out  32      Wishbone read data
//  tst_val     in   1       test-port request valid
//  tst_rdy     out  1       test-port request accepted when tst_val & tst_rdy
//  tst_we      in   1       test write
//  tst_adr     in   ADDR_W  test word address
//  tst_sel     in   4       test byte enables
//  tst_dat     in   32      test write data
//  tst_rd_val  out  1       one-cycle pulse, test read data valid
//  tst_rd_dat  out  32      test read data
//  sram_en     out  1       SRAM access strobe (one cycle per access, registered)
//  sram_we     out  1       SRAM write enable
//  sram_adr    out  ADDR_W  SRAM word address
//  sram_be     out  4       SRAM byte enables
//  sram_wdat   out  32      SRAM write data
//  sram_rdat   in   32      SRAM read data
//  busy        out  1       FSM not IDLE or FIFO non-empty
//  err         out  1       sticky: Wishbone FIFO overflow
// BEHAVIOUR
//  Reset:
//   - Outputs rd_ack, tst_rd_val, sram_en, sram_we, err, busy, tst_rdy = 0.
//   - rd_dat, tst_rd_dat, sram_adr, sram_be, sram_wdat = 0.
//   - FSM=IDLE; FIFO empty; rr pointer -> Wishbone wins the first tie.
//  WB FIFO:
//   - cmd_val pushes {we,sel,adr,dat}.
//   - Push and pop in the same cycle are legal, including when full.
//   - Push while full without a pop: command dropped, err set (cleared only by rst).
//  Arbitration:
//   - Evaluated only in IDLE. Candidates: FIFO non-empty, tst_val.
//   - One candidate: it wins. Both: the one not granted last wins; rr pointer updates on every grant.
//   - tst_rdy = IDLE & tst_val & test wins (combinational). WB grant pops the FIFO.
//  FSM:
//   - IDLE -grant-> ISSUE.
//   - ISSUE: sram_en=1 for exactly one cycle, with we/adr/be/wdat of the winner.
//       write -> IDLE (no response; Wishbone write ack is produced upstream);
//       read -> WAIT, cnt <= RD_LAT-1.
//   - WAIT: if cnt==0, capture sram_rdat and go to RESP; else cnt--.
//   - RESP: pulse rd_ack (WB owner) or tst_rd_val (test owner) for one cycle, data held until the next response; -> IDLE.
//  Latency:
//   - WB read with cmd_val in cycle T: sram_en at T+2, rd_ack at T+3+RD_LAT.
//   - Test read handshake in cycle T: sram_en at T+1, tst_rd_val at T+2+RD_LAT.
//   - Write: sram_en at T+2 (WB) / T+1 (test).
//  Throughput: one access in flight; reads block arbitration until RESP completes.
//  Reset mid-operation: FSM->IDLE, FIFO flushed, in-flight read discarded, no response pulse.
//  Address: upper cmd_adr bits above ADDR_W+1 ignored (decode done upstream); cmd_adr[1:0] ignored.
// TESTING
//  1. WB write adr 0x30000010 sel F dat A5A5A5A5, then WB read of the same address, RD_LAT=1
//     -> sram_en write at T+2 with adr 4; rd_ack with rd_dat A5A5A5A5 at T'+4.
//  2. cmd_val and tst_val (read adr 7) both pending in IDLE after reset
//     -> WB granted first, test next; tst_rdy high exactly one cycle.
//  3. 3 back-to-back WB writes while a test read is in WAIT, WB_DEPTH=2
//     -> first two written in order, third dropped, err=1 and stays 1.
//  4. RD_LAT=3, test read adr 0x12 with SRAM model returning 0xDEADBEEF
//     -> tst_rd_val at T+5 with 0xDEADBEEF; rd_ack stays 0.
//  5. rst asserted during WAIT of a WB read
//     -> no rd_ack; after reset busy=0, err=0, FIFO empty; next read completes normally.
//  6. Continuous tst_val plus WB pushes every 4 cycles
//     -> strict alternation of grants; no requester starved.

Source files
------------

// File: rtl/sram_cmd_sched.sv
// Schedules Wishbone and test-engine read/write commands onto a single-port SRAM.
// Wishbone commands are buffered in a small FIFO; a round-robin arbiter picks the next owner.
module sram_cmd_sched #(
  parameter int ADDR_W   = 8,
  parameter int RD_LAT   = 1,
  parameter int WB_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_val,
  input  logic [31:0]       cmd_adr,
  input  logic              cmd_we,
  input  logic [3:0]        cmd_sel,
  input  logic [31:0]       cmd_dat,
  output logic              rd_ack,
  output logic [31:0]       rd_dat,
  input  logic              tst_val,
  output logic              tst_rdy,
  input  logic              tst_we,
  input  logic [ADDR_W-1:0] tst_adr,
  input  logic [3:0]        tst_sel,
  input  logic [31:0]       tst_dat,
  output logic              tst_rd_val,
  output logic [31:0]       tst_rd_dat,
  output logic              sram_en,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_adr,
  output logic [3:0]        sram_be,
  output logic [31:0]       sram_wdat,
  input  logic [31:0]       sram_rdat,
  output logic              busy,
  output logic              err
);

  localparam int PTR_W = $clog2(WB_DEPTH);
  localparam int ENT_W = 1 + 4 + ADDR_W + 32;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_RESP  = 2'd3;

  logic [ENT_W-1:0]  fifo_mem [WB_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;
  logic              fifo_empty;
  logic              fifo_full;
  logic              push_ok;
  logic              pop;
  logic              head_we;
  logic [3:0]        head_sel;
  logic [ADDR_W-1:0] head_adr;
  logic [31:0]       head_dat;

  logic [1:0]        state;
  logic [3:0]        lat_cnt;
  logic              owner_tst;
  logic              last_tst;
  logic              idle;
  logic              wb_wins;
  logic              tst_wins;
  logic              grant_wb;
  logic              grant_tst;

  // Address bits outside the SRAM word range are decoded upstream.
  logic unused_adr;
  assign unused_adr = ^{cmd_adr[31:ADDR_W+2], cmd_adr[1:0]};

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == (PTR_W+1)'(WB_DEPTH));
  assign {head_we, head_sel, head_adr, head_dat} = fifo_mem[rd_ptr];

  // last_tst resets high so that Wishbone wins the first tie.
  assign idle      = (state == S_IDLE);
  assign wb_wins   = ~fifo_empty & (~tst_val | last_tst);
  assign tst_wins  = tst_val & (fifo_empty | ~last_tst);
  assign grant_wb  = idle & wb_wins;
  assign grant_tst = idle & tst_wins;
  assign tst_rdy   = grant_tst & ~rst;
  assign pop       = grant_wb;

  // A push into a full FIFO still fits when the head is popped in the same cycle.
  assign push_ok = cmd_val & (~fifo_full | pop);
  assign busy    = ~idle | ~fifo_empty;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= {cmd_we, cmd_sel, cmd_adr[ADDR_W+1:2], cmd_dat};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      err      <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      fifo_cnt <= fifo_cnt + (PTR_W+1)'(push_ok) - (PTR_W+1)'(pop);
      if (cmd_val & fifo_full & ~pop) err <= 1'b1;
    end
  end

  // Sequencer: one SRAM access in flight; read data is routed back to its owner.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      lat_cnt    <= '0;
      owner_tst  <= 1'b0;
      last_tst   <= 1'b1;
      sram_en    <= 1'b0;
      sram_we    <= 1'b0;
      sram_adr   <= '0;
      sram_be    <= '0;
      sram_wdat  <= '0;
      rd_ack     <= 1'b0;
      rd_dat     <= '0;
      tst_rd_val <= 1'b0;
      tst_rd_dat <= '0;
    end else begin
      sram_en    <= 1'b0;
      rd_ack     <= 1'b0;
      tst_rd_val <= 1'b0;
      case (state)
        S_IDLE: begin
          if (grant_wb) begin
            sram_en   <= 1'b1;
            sram_we   <= head_we;
            sram_adr  <= head_adr;
            sram_be   <= head_sel;
            sram_wdat <= head_dat;
            owner_tst <= 1'b0;
            last_tst  <= 1'b0;
            state     <= S_ISSUE;
          end else if (grant_tst) begin
            sram_en   <= 1'b1;
            sram_we   <= tst_we;
            sram_adr  <= tst_adr;
            sram_be   <= tst_sel;
            sram_wdat <= tst_dat;
            owner_tst <= 1'b1;
            last_tst  <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (sram_we) begin
            state <= S_IDLE;
          end else begin
            lat_cnt <= 4'(RD_LAT - 1);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (lat_cnt == '0) begin
            if (owner_tst) begin
              tst_rd_dat <= sram_rdat;
              tst_rd_val <= 1'b1;
            end else begin
              rd_dat <= sram_rdat;
              rd_ack <= 1'b1;
            end
            state <= S_RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_cmd_sched.sv
// Bench for sram_cmd_sched: two instances (RD_LAT=1 and RD_LAT=3) share one stimulus stream,
// each with its own SRAM model whose read data is only valid exactly RD_LAT cycles after sram_en.
module tb_sram_cmd_sched;

  typedef struct {
    logic        chk;
    logic        rst;
    logic        cv;
    logic [31:0] ca;
    logic        cw;
    logic [31:0] cd;
    logic        tv;
    logic        tw;
    logic [7:0]  ta;
    logic [31:0] td;
    logic        e_en;
    logic        e_we;
    logic [7:0]  e_adr;
    logic        e_ack;
    logic [31:0] e_rdat;
    logic        e_trdy;
    logic        e_tval;
    logic [31:0] e_tdat;
    logic        e_busy;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_val = 1'b0;
  logic [31:0] cmd_adr = '0;
  logic        cmd_we = 1'b0;
  logic [3:0]  cmd_sel = 4'hF;
  logic [31:0] cmd_dat = '0;
  logic        tst_val = 1'b0;
  logic        tst_we = 1'b0;
  logic [7:0]  tst_adr = '0;
  logic [3:0]  tst_sel = 4'hF;
  logic [31:0] tst_dat = '0;

  logic        rd_ack1, tst_rdy1, tst_rd_val1, sram_en1, sram_we1, busy1, err1;
  logic [31:0] rd_dat1, tst_rd_dat1, sram_wdat1, sram_rdat1;
  logic [7:0]  sram_adr1;
  logic [3:0]  sram_be1;
  logic        rd_ack3, tst_rdy3, tst_rd_val3, sram_en3, sram_we3, busy3, err3;
  logic [31:0] rd_dat3, tst_rd_dat3, sram_wdat3, sram_rdat3;
  logic [7:0]  sram_adr3;
  logic [3:0]  sram_be3;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  sram_cmd_sched #(.ADDR_W(8), .RD_LAT(1), .WB_DEPTH(2)) dut1 (
    .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_dat(cmd_dat), .rd_ack(rd_ack1), .rd_dat(rd_dat1),
    .tst_val(tst_val), .tst_rdy(tst_rdy1), .tst_we(tst_we), .tst_adr(tst_adr),
    .tst_sel(tst_sel), .tst_dat(tst_dat), .tst_rd_val(tst_rd_val1), .tst_rd_dat(tst_rd_dat1),
    .sram_en(sram_en1), .sram_we(sram_we1), .sram_adr(sram_adr1), .sram_be(sram_be1),
    .sram_wdat(sram_wdat1), .sram_rdat(sram_rdat1), .busy(busy1), .err(err1)
  );

  sram_cmd_sched #(.ADDR_W(8), .RD_LAT(3), .WB_DEPTH(2)) dut3 (
    .clk(clk), .rst(rst), .cmd_val(cmd_val), .cmd_adr(cmd_adr), .cmd_we(cmd_we),
    .cmd_sel(cmd_sel), .cmd_dat(cmd_dat), .rd_ack(rd_ack3), .rd_dat(rd_dat3),
    .tst_val(tst_val), .tst_rdy(tst_rdy3), .tst_we(tst_we), .tst_adr(tst_adr),
    .tst_sel(tst_sel), .tst_dat(tst_dat), .tst_rd_val(tst_rd_val3), .tst_rd_dat(tst_rd_dat3),
    .sram_en(sram_en3), .sram_we(sram_we3), .sram_adr(sram_adr3), .sram_be(sram_be3),
    .sram_wdat(sram_wdat3), .sram_rdat(sram_rdat3), .busy(busy3), .err(err3)
  );

  // SRAM models; a poison word appears on every cycle that is not a valid read slot.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (sram_en1 && sram_we1)
      for (int b = 0; b < 4; b++)
        if (sram_be1[b]) mem1[sram_adr1][b*8 +: 8] <= sram_wdat1[b*8 +: 8];
    pipe1 <= (sram_en1 && !sram_we1) ? mem1[sram_adr1] : 32'hBAD0_BAD0;
  end
  assign sram_rdat1 = pipe1;

  always @(posedge clk) begin
    if (sram_en3 && sram_we3)
      for (int b = 0; b < 4; b++)
        if (sram_be3[b]) mem3[sram_adr3][b*8 +: 8] <= sram_wdat3[b*8 +: 8];
    pipe3[0] <= (sram_en3 && !sram_we3) ? mem3[sram_adr3] : 32'hBAD0_BAD0;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign sram_rdat3 = pipe3[2];

  function automatic vec_t mk(input logic chk, input logic r, input logic cv, input logic [31:0] ca,
                              input logic cw, input logic [31:0] cd, input logic tv, input logic [7:0] ta,
                              input logic e_en, input logic e_we, input logic [7:0] e_adr,
                              input logic e_ack, input logic [31:0] e_rdat, input logic e_trdy,
                              input logic e_tval, input logic [31:0] e_tdat, input logic e_busy);
    vec_t v;
    v = '{default: 0};
    v.chk = chk; v.rst = r; v.cv = cv; v.ca = ca; v.cw = cw; v.cd = cd; v.tv = tv; v.ta = ta;
    v.e_en = e_en; v.e_we = e_we; v.e_adr = e_adr; v.e_ack = e_ack; v.e_rdat = e_rdat;
    v.e_trdy = e_trdy; v.e_tval = e_tval; v.e_tdat = e_tdat; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One cycle: drive after the rising edge, leave outputs to be sampled at the falling edge.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst = v.rst; cmd_val = v.cv; cmd_adr = v.ca; cmd_we = v.cw; cmd_dat = v.cd;
    tst_val = v.tv; tst_we = v.tw; tst_adr = v.ta; tst_dat = v.td;
    @(negedge clk);
  endtask

  task automatic drive(input logic cv, input logic [31:0] ca, input logic cw, input logic [31:0] cd,
                       input logic tv, input logic tw, input logic [7:0] ta, input logic [31:0] td);
    vec_t v;
    v = mk(0, 0, cv, ca, cw, cd, tv, ta, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    v.tw = tw;
    v.td = td;
    applyStimulus(v);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  vec_t        tbl [20];
  logic [15:0] h_a, h_b, h_c;
  logic [40:0] wlog [$];
  logic [7:0]  log1 [$];
  logic [7:0]  log3 [$];
  int          tcount;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem1[i] = {4{8'(i)}};
      mem3[i] = {4{8'(i)}};
    end
    mem3[8'h12] = 32'hDEAD_BEEF;

    // Test 1 (WB write then read, RD_LAT=1) and test 2 (WB/test tie after reset).
    tbl[0]  = mk(1,0, 1,32'h3000_0010,1,32'hA5A5_A5A5, 0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            0);
    tbl[1]  = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            1);
    tbl[2]  = mk(1,0, 0,0,0,0,                        0,8'h00, 1,1,8'h04, 0,0,            0,0,0,            1);
    tbl[3]  = mk(1,0, 1,32'h3000_0010,0,0,            0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            0);
    tbl[4]  = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            1);
    tbl[5]  = mk(1,0, 0,0,0,0,                        0,8'h00, 1,0,8'h04, 0,0,            0,0,0,            1);
    tbl[6]  = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            1);
    tbl[7]  = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 1,32'hA5A5_A5A5,0,0,0,            1);
    tbl[8]  = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,32'hA5A5_A5A5,0,0,0,            0);
    tbl[9]  = mk(0,1, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            0);
    tbl[10] = mk(1,0, 1,32'h0000_0020,0,0,            0,8'h00, 0,0,8'h00, 0,0,            0,0,0,            0);
    tbl[11] = mk(1,0, 0,0,0,0,                        1,8'h07, 0,0,8'h00, 0,0,            0,0,0,            1);
    tbl[12] = mk(1,0, 0,0,0,0,                        1,8'h07, 1,0,8'h08, 0,0,            0,0,0,            1);
    tbl[13] = mk(1,0, 0,0,0,0,                        1,8'h07, 0,0,8'h00, 0,0,            0,0,0,            1);
    tbl[14] = mk(1,0, 0,0,0,0,                        1,8'h07, 0,0,8'h00, 1,32'h0808_0808,0,0,0,            1);
    tbl[15] = mk(1,0, 0,0,0,0,                        1,8'h07, 0,0,8'h00, 0,32'h0808_0808,1,0,0,            0);
    tbl[16] = mk(1,0, 0,0,0,0,                        0,8'h00, 1,0,8'h07, 0,32'h0808_0808,0,0,0,            1);
    tbl[17] = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,32'h0808_0808,0,0,0,            1);
    tbl[18] = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,32'h0808_0808,0,1,32'h0707_0707,1);
    tbl[19] = mk(1,0, 0,0,0,0,                        0,8'h00, 0,0,8'h00, 0,32'h0808_0808,0,0,32'h0707_0707,0);

    // Reset state of both instances.
    repeat (2) applyStimulus(mk(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0));
    checkOutput("reset_dut1", {rd_ack1, rd_dat1, tst_rdy1, tst_rd_val1, tst_rd_dat1, sram_en1, sram_we1,
                               sram_adr1, sram_be1, sram_wdat1, busy1, err1}, '0);
    checkOutput("reset_dut3", {rd_ack3, rd_dat3, tst_rdy3, tst_rd_val3, tst_rd_dat3, sram_en3, sram_we3,
                               sram_adr3, sram_be3, sram_wdat3, busy3, err3}, '0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(tbl[i]);
      if (tbl[i].chk)
        checkOutput($sformatf("vec%0d", i),
          {sram_en1, sram_en1 & sram_we1, sram_en1 ? sram_adr1 : 8'h00, rd_ack1, rd_dat1,
           tst_rdy1, tst_rd_val1, tst_rd_dat1, busy1},
          {tbl[i].e_en, tbl[i].e_we, tbl[i].e_adr, tbl[i].e_ack, tbl[i].e_rdat,
           tbl[i].e_trdy, tbl[i].e_tval, tbl[i].e_tdat, tbl[i].e_busy});
    end
    idle(10);

    // Test 3: three WB writes behind a test read; the third overflows the FIFO.
    drive(0, 0, 0, 0, 1, 0, 8'h07, 0);
    checkOutput("t3_rdy", tst_rdy1, 1);
    drive(1, 32'h80, 1, 32'h111, 0, 0, 0, 0);
    drive(1, 32'h84, 1, 32'h222, 0, 0, 0, 0);
    drive(1, 32'h88, 1, 32'h333, 0, 0, 0, 0);
    checkOutput("t3_err_pre", err1, 0);
    checkOutput("t3_tval", {tst_rd_val1, tst_rd_dat1}, {1'b1, 32'h0707_0707});
    h_a = '0;
    wlog.delete();
    for (int k = 4; k <= 12; k++) begin
      idle(1);
      if (k == 4) checkOutput("t3_err_set", err1, 1);
      h_a[k] = sram_en1;
      if (sram_en1) wlog.push_back({sram_we1, sram_adr1, sram_wdat1});
    end
    checkOutput("t3_en_timing", h_a, 16'h00A0);
    checkOutput("t3_wr_count", wlog.size(), 2);
    checkOutput("t3_wr0", wlog[0], {1'b1, 8'h20, 32'h111});
    checkOutput("t3_wr1", wlog[1], {1'b1, 8'h21, 32'h222});
    checkOutput("t3_err3", err3, 1);
    idle(6);

    // Test 4: RD_LAT=3 test read of 0x12.
    drive(0, 0, 0, 0, 1, 0, 8'h12, 0);
    checkOutput("t4_rdy", tst_rdy3, 1);
    h_a = '0; h_b = '0; h_c = '0;
    for (int k = 1; k <= 7; k++) begin
      idle(1);
      h_a[k] = sram_en3;
      h_b[k] = tst_rd_val3;
      h_c[k] = rd_ack3;
      if (k == 5) checkOutput("t4_data", tst_rd_dat3, 32'hDEAD_BEEF);
    end
    checkOutput("t4_en_timing", h_a, 16'h0002);
    checkOutput("t4_tval_timing", h_b, 16'h0020);
    checkOutput("t4_no_rdack", h_c, 16'h0000);
    checkOutput("t3_err_sticky", err1, 1);
    idle(4);

    // Test 5: reset during WAIT of a WB read, with a write still queued.
    h_a = '0; h_b = '0;
    drive(1, 32'h48, 0, 0, 0, 0, 0, 0);
    h_a[0] = rd_ack3;
    for (int k = 1; k <= 12; k++) begin
      if (k == 3) drive(1, 32'hC0, 1, 32'h5555_5555, 0, 0, 0, 0);
      else if (k == 4) applyStimulus(mk(0,1, 0,0,0,0, 0,0, 0,0,0, 0,0, 0,0,0, 0));
      else idle(1);
      h_a[k] = rd_ack3;
      if (k >= 5) h_b[k] = sram_en1 | sram_en3;
      if (k == 5) checkOutput("t5_after_rst", {busy1, err1, busy3, err3}, 4'b0000);
    end
    checkOutput("t5_no_rdack", h_a, 16'h0000);
    checkOutput("t5_flushed", h_b, 16'h0000);
    h_a = '0; h_b = '0;
    drive(1, 32'h48, 0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 8; k++) begin
      idle(1);
      h_a[k] = rd_ack1;
      h_b[k] = rd_ack3;
      if (k == 4) checkOutput("t5_dat1", rd_dat1, 32'h1212_1212);
      if (k == 6) checkOutput("t5_dat3", rd_dat3, 32'hDEAD_BEEF);
    end
    checkOutput("t5_ack1_timing", h_a, 16'h0010);
    checkOutput("t5_ack3_timing", h_b, 16'h0040);
    idle(4);

    // Test 6: continuous test writes with a WB write every 4 cycles.
    tcount = 0;
    log1.delete();
    log3.delete();
    for (int c = 0; c < 38; c++) begin
      if (c < 32)
        drive((c % 4) == 0, 32'h100 + 32'(4 * (c / 4)), 1, 32'(c), 1, 1, 8'h80 + 8'(tcount), 32'(c));
      else
        idle(1);
      if (tst_rdy1) tcount++;
      if (sram_en1) log1.push_back(sram_adr1);
      if (sram_en3) log3.push_back(sram_adr3);
    end
    checkOutput("t6_count1", log1.size(), 16);
    checkOutput("t6_count3", log3.size(), 16);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t6_pair%0d_dut1", i), {log1[2*i], log1[2*i+1]}, {8'h80 + 8'(i), 8'h40 + 8'(i)});
      checkOutput($sformatf("t6_pair%0d_dut3", i), {log3[2*i], log3[2*i+1]}, {8'h80 + 8'(i), 8'h40 + 8'(i)});
    end
    checkOutput("t6_no_err", {err1, err3}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
